alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor to the team's registered ALU. It accepts one operation per valid/ready transfer and completes single-cycle operations in one clock. Multiply operations run for a configurable number of cycles. Each result is held in a one-entry output buffer until the downstream stage takes it. The block sits between the command issue stage and result writeback, and stalls the issuer through `in_ready`.

## Interface
- `W`, default 8: operand width, must be ≥ 4.
- `MUL_LAT`, default 3: multiply latency in cycles, must be ≥ 1.
- `RB`, default $clog2(W): number of rotate-amount bits.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: a command is presented.
- `in_ready`, output, 1: the block can accept a command this cycle.
- `opa`, `opb`, input, W: operands.
- `cmd`, input, 4: operation code.
- `mode`, input, 1: 1 = arithmetic, 0 = logic.
- `cin`, input, 1: carry/borrow in.
- `opv`, input, 2: operand valid bits; [0] = opa, [1] = opb.
- `out_valid`, output, 1: a result is held.
- `out_ready`, input, 1: the consumer takes the held result.
- `res`, output, 2W: result, zero-extended.
- `err`, `oflow`, `cout`, `g`, `l`, `e`, output, 1: status flags, qualified by `out_valid`.

## Operation
- **Transfer.** A command is accepted when `in_valid && in_ready`. At accept, `opa`, `opb`, `cmd`, `mode`, `cin` and `opv` are captured.
- **Ready.** `in_ready = (state==IDLE) && (!out_valid || out_ready)`. It is combinational and does not depend on `in_valid`.
- **State machine:**
  - IDLE: accepting a multiply moves to MUL with the counter loaded to MUL_LAT-1. Accepting any other command writes the output buffer directly.
  - MUL: the counter decrements each cycle. At counter==0 the result is written to the output buffer and the state returns to IDLE.
  - MUL_LAT=1 bypasses MUL entirely.
- **Output buffer.**
  - The buffer is loaded with `out_valid` set to 1.
  - `out_valid` clears on `out_ready` when no new load happens in the same cycle.
  - A load and a take in the same cycle leave `out_valid` at 1 with the new data.
  - While `out_valid && !out_ready`, `res` and all flags are held stable.
- **Arithmetic ops (mode=1); required `opv` in brackets:**
  - 0: ADD [11]
  - 1: SUB [11]
  - 2: ADD+cin [11]
  - 3: SUB−cin [11]
  - 4: INC A [01]
  - 5: DEC A [01]
  - 6: INC B [10]
  - 7: DEC B [10]
  - 8: unsigned compare, sets g/l/e [11]
  - 9: multiply (A+1)*(B+1) [11]
  - 10: multiply (A>>1)*B [11]
  - 11: signed ADD [11]
  - 12: signed SUB [11]
- **Carry and overflow.**
  - Ops 2, 3, 11 and 12 set `cout = res[W]`.
  - Ops 11 and 12 set `oflow` by the W-bit two's-complement rule. Ops 11 and 12 also set g/l/e from a signed compare.
  - Subtraction is computed modulo 2^(W+1) and zero-extended; `res[W]` is the borrow.
- **Logic ops (mode=0); required `opv` in brackets:**
  - 0: AND [11]
  - 1: NAND [11]
  - 2: OR [11]
  - 3: NOR [11]
  - 4: XOR [11]
  - 5: XNOR [11]
  - 6: NOT A [01]
  - 7: NOT B [10]
  - 8: SHL A [01]
  - 9: SHR A [01]
  - 10: SHL B [10]
  - 11: SHR B [10]
  - 12: ROL A by opb[RB-1:0] [11]
  - 13: ROR A by opb[RB-1:0] [11]
- **Bit-vector results.** Logic results occupy `res[W-1:0]`; the upper bits are 0. A shift-left result keeps the carried-out bit in `res[W]`.
- **Rotate range check.** For rotates, any nonzero `opb[W-1:RB]` sets `err`.
- **Errors.**
  - An `opv` mismatch, an undefined cmd, or a rotate range violation sets `err`=1 and forces `res`=0 and all other flags to 0.
  - An erroneous multiply does not enter MUL; it completes in one cycle.
- **Unused flags** are 0 for every operation that does not define them.

## Timing
- **Reset values.**
  - `res`=0, all flags 0, `out_valid`=0, state=IDLE, counter=0.
  - `in_ready`=1 in the first cycle after reset deassert.
- **Single-cycle op.** Accepted at edge k, `out_valid`=1 after edge k.
- **Multiply.**
  - Accepted at edge k, `out_valid`=1 after edge k+MUL_LAT.
  - `in_ready`=0 from edge k until the result loads.
- **Back-to-back.** With `out_ready` held at 1, single-cycle ops sustain one per cycle.
- **Reset mid-multiply.** The operation is aborted, its result is discarded, and no `out_valid` pulse is produced.
- **Backpressure.** A completed multiply with the buffer full is not possible, because the block accepts only when the buffer will be free.
- **Idle inputs.** Inputs are ignored while `!in_ready`.

## Test plan
- **Reset.** Assert rst mid-stream -> `res`=0, flags 0, `out_valid`=0, `in_ready`=1 after release.
- **Unsigned add.** W=8, mode=1, cmd=0, A=0xFF, B=0x01, opv=11 -> `res`=0x0100 one cycle after accept.
- **Signed add overflow.** cmd=11, A=0x7F, B=0x01 -> `res[7:0]`=0x80, `oflow`=1, g=1.
- **Multiply latency.** MUL_LAT=3, cmd=9, A=3, B=4 -> `res`=20 exactly 3 cycles after accept, `in_ready`=0 for those cycles.
  - rst pulse in cycle 2 -> no `out_valid`.
- **Backpressure.** Hold `out_ready`=0 after an AND result -> `res` stable, `in_ready`=0.
  - Release -> the next command is accepted the same cycle.
  - Back-to-back XOR ops then yield one result per cycle.
- **Error paths.**
  - mode=0, cmd=12, opv=11, A=0x81, B=0x01 -> `res`=0x0003.
  - B=0x11 -> `err`=1, `res`=0.
  - cmd=4 with opv=01 -> `err`=1.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a multi-cycle multiplier and a one-entry
// output buffer. Single-cycle ops write the buffer at accept; multiplies
// run MUL_LAT cycles from captured operands before writing it.
module alu_pipe #(
  parameter int unsigned W       = 8,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned RB      = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   opa,
  input  logic [W-1:0]   opb,
  input  logic [3:0]     cmd,
  input  logic           mode,
  input  logic           cin,
  input  logic [1:0]     opv,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] res,
  output logic           err,
  output logic           oflow,
  output logic           cout,
  output logic           g,
  output logic           l,
  output logic           e
);

  localparam int unsigned RW = 2 * W;
  localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [W:0]  ONE = (W + 1)'(1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Operands captured at accept; only consumed while a multiply is running.
  logic [W-1:0]   a_q, b_q;
  logic [3:0]     cmd_q;
  logic           mode_q, cin_q;
  logic [1:0]     opv_q;

  // Operand source for the shared datapath.
  logic [W-1:0]   a, b;
  logic [3:0]     op;
  logic           md, ci;
  logic [1:0]     ov;

  // Datapath results.
  logic [RW-1:0]  c_res;
  logic           c_err, c_oflow, c_cout, c_g, c_l, c_e, c_mul;

  // Output buffer.
  logic [RW-1:0]  res_q;
  logic           ov_q, err_q, oflow_q, cout_q, g_q, l_q, e_q;

  logic           accept, go_mul, mul_done, load;

  // Datapath scratch.
  logic [W:0]     ax, bx, sum;
  logic [W-1:0]   lg, rol, ror;
  logic [RW-1:0]  pa, pb;
  logic [1:0]     need;
  logic           defined, range_ok, is_mul;
  int unsigned    amt;

  assign in_ready = (state_q == IDLE) && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign go_mul   = accept && c_mul && (MUL_LAT > 1);
  assign mul_done = (state_q == MUL) && (cnt_q == '0);
  assign load     = (accept && !go_mul) || mul_done;

  // While multiplying, the datapath evaluates the captured command.
  always_comb begin
    if (state_q == MUL) begin
      a = a_q; b = b_q; op = cmd_q; md = mode_q; ci = cin_q; ov = opv_q;
    end else begin
      a = opa; b = opb; op = cmd; md = mode; ci = cin; ov = opv;
    end
  end

  // Combinational ALU: result, flags and error detection for one command.
  always_comb begin
    ax       = {1'b0, a};
    bx       = {1'b0, b};
    sum      = '0;
    lg       = '0;
    pa       = '0;
    pb       = '0;
    need     = 2'b11;
    defined  = 1'b1;
    is_mul   = 1'b0;
    c_res    = '0;
    c_oflow  = 1'b0;
    c_cout   = 1'b0;
    c_g      = 1'b0;
    c_l      = 1'b0;
    c_e      = 1'b0;
    amt      = 32'(b[RB-1:0]) % W;
    rol      = (a << amt) | (a >> (W - amt));
    ror      = (a >> amt) | (a << (W - amt));
    range_ok = 1'b1;
    if (md) begin
      case (op)
        4'd0:  begin sum = ax + bx; c_res = RW'(sum); end
        4'd1:  begin sum = ax - bx; c_res = RW'(sum); end
        4'd2:  begin sum = ax + bx + (W + 1)'(ci); c_res = RW'(sum); c_cout = sum[W]; end
        4'd3:  begin sum = ax - bx - (W + 1)'(ci); c_res = RW'(sum); c_cout = sum[W]; end
        4'd4:  begin need = 2'b01; sum = ax + ONE; c_res = RW'(sum); end
        4'd5:  begin need = 2'b01; sum = ax - ONE; c_res = RW'(sum); end
        4'd6:  begin need = 2'b10; sum = bx + ONE; c_res = RW'(sum); end
        4'd7:  begin need = 2'b10; sum = bx - ONE; c_res = RW'(sum); end
        4'd8:  begin c_g = (a > b); c_l = (a < b); c_e = (a == b); end
        4'd9:  begin
          is_mul = 1'b1;
          pa     = RW'(ax + ONE);
          pb     = RW'(bx + ONE);
          c_res  = pa * pb;
        end
        4'd10: begin
          is_mul = 1'b1;
          pa     = RW'(a >> 1);
          pb     = RW'(b);
          c_res  = pa * pb;
        end
        4'd11: begin
          sum     = ax + bx;
          c_res   = RW'(sum);
          c_cout  = sum[W];
          c_oflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
          c_g     = ($signed(a) > $signed(b));
          c_l     = ($signed(a) < $signed(b));
          c_e     = (a == b);
        end
        4'd12: begin
          sum     = ax - bx;
          c_res   = RW'(sum);
          c_cout  = sum[W];
          c_oflow = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
          c_g     = ($signed(a) > $signed(b));
          c_l     = ($signed(a) < $signed(b));
          c_e     = (a == b);
        end
        default: defined = 1'b0;
      endcase
    end else begin
      // Bit-vector ops go through lg so the inversions stay W bits wide.
      case (op)
        4'd0:  begin lg = a & b;    c_res = RW'(lg); end
        4'd1:  begin lg = ~(a & b); c_res = RW'(lg); end
        4'd2:  begin lg = a | b;    c_res = RW'(lg); end
        4'd3:  begin lg = ~(a | b); c_res = RW'(lg); end
        4'd4:  begin lg = a ^ b;    c_res = RW'(lg); end
        4'd5:  begin lg = ~(a ^ b); c_res = RW'(lg); end
        4'd6:  begin need = 2'b01; lg = ~a; c_res = RW'(lg); end
        4'd7:  begin need = 2'b10; lg = ~b; c_res = RW'(lg); end
        4'd8:  begin need = 2'b01; sum = {a, 1'b0}; c_res = RW'(sum); end
        4'd9:  begin need = 2'b01; lg = a >> 1; c_res = RW'(lg); end
        4'd10: begin need = 2'b10; sum = {b, 1'b0}; c_res = RW'(sum); end
        4'd11: begin need = 2'b10; lg = b >> 1; c_res = RW'(lg); end
        4'd12: begin range_ok = (b[W-1:RB] == '0); c_res = RW'(rol); end
        4'd13: begin range_ok = (b[W-1:RB] == '0); c_res = RW'(ror); end
        default: defined = 1'b0;
      endcase
    end
    c_err = !defined || (ov != need) || !range_ok;
    c_mul = is_mul && !c_err;
    if (c_err) begin
      c_res   = '0;
      c_oflow = 1'b0;
      c_cout  = 1'b0;
      c_g     = 1'b0;
      c_l     = 1'b0;
      c_e     = 1'b0;
    end
  end

  // Next-state and multiply countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (go_mul) begin
          state_d = MUL;
          cnt_d   = CW'(MUL_LAT - 1);
        end
      end
      MUL: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command capture at every accepted transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cmd_q  <= '0;
      mode_q <= 1'b0;
      cin_q  <= 1'b0;
      opv_q  <= '0;
    end else if (accept) begin
      a_q    <= opa;
      b_q    <= opb;
      cmd_q  <= cmd;
      mode_q <= mode;
      cin_q  <= cin;
      opv_q  <= opv;
    end
  end

  // Output buffer: a load wins over a same-cycle take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q    <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      oflow_q <= 1'b0;
      cout_q  <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      if (load) begin
        ov_q    <= 1'b1;
        res_q   <= c_res;
        err_q   <= c_err;
        oflow_q <= c_oflow;
        cout_q  <= c_cout;
        g_q     <= c_g;
        l_q     <= c_l;
        e_q     <= c_e;
      end else if (out_ready) begin
        ov_q    <= 1'b0;
      end
    end
  end

  assign out_valid = ov_q;
  assign res       = res_q;
  assign err       = err_q;
  assign oflow     = oflow_q;
  assign cout      = cout_q;
  assign g         = g_q;
  assign l         = l_q;
  assign e         = e_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (W=8, MUL_LAT=3): stimulus pushes expected
// results at accept; a monitor pops and compares at every output transfer.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  opa = '0, opb = '0;
  logic [3:0]  cmd = '0;
  logic        mode = 1'b0, cin = 1'b0;
  logic [1:0]  opv = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] res;
  logic        err, oflow, cout, g, l, e;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          nres = 0;
  logic [21:0] sb[$];

  localparam logic [5:0] F_ERR = 6'b100000;
  localparam logic [5:0] F_OFL = 6'b010000;
  localparam logic [5:0] F_CO  = 6'b001000;
  localparam logic [5:0] F_G   = 6'b000100;
  localparam logic [5:0] F_L   = 6'b000010;

  alu_pipe #(.W(8), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opa(opa), .opb(opb), .cmd(cmd), .mode(mode), .cin(cin), .opv(opv),
    .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .err(err), .oflow(oflow), .cout(cout), .g(g), .l(l), .e(e)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every result the consumer takes against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got res=%h flags=%b, nothing expected",
                 res, {err, oflow, cout, g, l, e});
      end else begin
        chk($sformatf("result[%0d]", nres), {10'd0, res, err, oflow, cout, g, l, e},
            {10'd0, sb.pop_front()});
        nres++;
      end
    end
  end

  // Present one command, wait (bounded) for acceptance, record its expectation.
  task automatic send(input logic m, input logic [3:0] c, input logic [7:0] a,
                      input logic [7:0] b, input logic ci, input logic [1:0] v,
                      input logic [15:0] r, input logic [5:0] fl);
    int unsigned n = 0;
    mode = m; cmd = c; opa = a; opb = b; cin = ci; opv = v; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end else begin
      sb.push_back({r, fl});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    int t0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_flags", {err, oflow, cout, g, l, e}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Arithmetic
    send(1, 4'd0,  8'hFF, 8'h01, 0, 2'b11, 16'h0100, 6'b0);
    chk("add_latency", out_valid, 1);
    send(1, 4'd1,  8'h05, 8'h07, 0, 2'b11, 16'h01FE, 6'b0);
    send(1, 4'd2,  8'hFF, 8'h00, 1, 2'b11, 16'h0100, F_CO);
    send(1, 4'd3,  8'h10, 8'h05, 1, 2'b11, 16'h000A, 6'b0);
    send(1, 4'd4,  8'hFF, 8'h00, 0, 2'b01, 16'h0100, 6'b0);
    send(1, 4'd7,  8'h00, 8'h00, 0, 2'b10, 16'h01FF, 6'b0);
    send(1, 4'd8,  8'h03, 8'h09, 0, 2'b11, 16'h0000, F_L);
    send(1, 4'd11, 8'h7F, 8'h01, 0, 2'b11, 16'h0080, F_OFL | F_G);
    send(1, 4'd12, 8'h80, 8'h01, 0, 2'b11, 16'h007F, F_OFL | F_L);
    // Logic
    send(0, 4'd0,  8'hF0, 8'h3C, 0, 2'b11, 16'h0030, 6'b0);
    send(0, 4'd1,  8'hF0, 8'h3C, 0, 2'b11, 16'h00CF, 6'b0);
    send(0, 4'd8,  8'h81, 8'h00, 0, 2'b01, 16'h0102, 6'b0);
    send(0, 4'd11, 8'h00, 8'h81, 0, 2'b10, 16'h0040, 6'b0);
    send(0, 4'd12, 8'h81, 8'h01, 0, 2'b11, 16'h0003, 6'b0);
    send(0, 4'd13, 8'h81, 8'h01, 0, 2'b11, 16'h00C0, 6'b0);
    // Errors
    send(0, 4'd12, 8'h81, 8'h11, 0, 2'b11, 16'h0000, F_ERR);
    send(0, 4'd4,  8'h81, 8'h01, 0, 2'b01, 16'h0000, F_ERR);
    send(1, 4'd14, 8'h81, 8'h01, 0, 2'b11, 16'h0000, F_ERR);

    @(posedge clk); #1;
    chk("idle_empty", out_valid, 0);

    // Multiply latency and in_ready stall
    send(1, 4'd9, 8'h03, 8'h04, 0, 2'b11, 16'h0014, 6'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("mul_out_valid[%0d]", c), out_valid, (c == 3));
      chk($sformatf("mul_in_ready[%0d]", c), in_ready, (c == 3));
    end
    @(posedge clk); #1;
    send(1, 4'd10, 8'h0F, 8'h11, 0, 2'b11, 16'h0077, 6'b0);
    send(1, 4'd9,  8'hFE, 8'h01, 0, 2'b11, 16'h01FE, 6'b0);

    // Erroneous multiply completes in one cycle
    repeat (6) @(posedge clk);
    #1;
    chk("pre_errmul_empty", out_valid, 0);
    send(1, 4'd9, 8'h03, 8'h04, 0, 2'b01, 16'h0000, F_ERR);
    chk("errmul_latency", out_valid, 1);
    chk("errmul_in_ready", in_ready, 1);

    // Backpressure: hold AND result, an XOR waits on in_valid meanwhile
    send(0, 4'd0, 8'h0F, 8'hFF, 0, 2'b11, 16'h000F, 6'b0);
    out_ready = 1'b0;
    mode = 0; cmd = 4'd4; opa = 8'h55; opb = 8'h0F; opv = 2'b11; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_res", res, 16'h000F);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    sb.push_back({16'h005A, 6'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release_res", res, 16'h005A);

    // Back-to-back XORs, one per cycle
    t0 = cyc;
    send(0, 4'd4, 8'hFF, 8'h0F, 0, 2'b11, 16'h00F0, 6'b0);
    send(0, 4'd4, 8'hAA, 8'h55, 0, 2'b11, 16'h00FF, 6'b0);
    send(0, 4'd4, 8'h12, 8'h34, 0, 2'b11, 16'h0026, 6'b0);
    chk("b2b_cycles", cyc - t0, 3);
    chk("b2b_out_valid", out_valid, 1);

    // Reset in the second cycle of a multiply aborts it
    @(posedge clk); #1;
    mode = 1; cmd = 4'd9; opa = 8'h02; opb = 8'h02; opv = 2'b11; in_valid = 1'b1;
    @(negedge clk);
    chk("rm_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rm_during_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rm_res", res, 0);
    chk("rm_flags", {err, oflow, cout, g, l, e}, 0);
    chk("rm_in_ready", in_ready, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rm_after_valid", out_valid, 0);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
